// File: rtl/wed_done_control.sv
// wed_done_control: writes one 128-byte completion status cacheline to wed_address + DONE_OFFSET via WRITE_NA.
//
// Ports:
//   clock, rstn                  clock and asynchronous active-low reset
//   enabled_in                   AFU enable, registered once before use
//   wed_address [0:63]           WED base effective address
//   done_in, status_in [0:63]    kernel completion pulse and its status word
//   command_buffer_status        command buffer flow control (alfull gates every issue)
//   wed_response_in              PSL response stream (only cu_id == WED_ID is consumed)
//   command_out                  WRITE_NA command to the command buffer
//   write_data_0_out/_1_out      status line bits [0:511] / [512:1023]
//   done_out, error_out          sticky completion / retries-exhausted flags
//
// Optional: define WED_DONE_CYCLE_COUNT_EN to place a 64-bit enabled-cycle count in line bits [128:191].

package wed_done_pkg;
    typedef enum logic [2:0] {STRICT, ABORT, PAGE, PREF, SPEC} trans_order_t;
    typedef enum logic [3:0] {INVALID, READ_CL_NA, WRITE_NA, WRITE_MS} command_t;
    typedef enum logic [3:0] {DONE, AERROR, DERROR, NLOCK, NRES, FLUSHED, FAULT, FAILED, PAGED, CONTEXT} response_t;
    typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE, CMD_WED} cmd_type_t;
    typedef enum logic [1:0] {STRUCT_INVALID, STRUCT_GRAPH, STRUCT_VERTEX, STRUCT_EDGE} array_struct_t;
    typedef logic [7:0] cu_id_t;

    localparam cu_id_t INVALID_ID = 8'hFF;
    localparam cu_id_t WED_ID     = 8'h01;

    typedef struct packed {
        cu_id_t        cu_id;
        cmd_type_t     cmd_type;
        array_struct_t array_struct;
        logic [0:7]    real_size;
        logic [0:7]    tag;
        logic [0:6]    cacheline_offset;
        logic [0:31]   address_offset;
    } command_tag_t;

    typedef struct packed {
        logic alfull;
        logic full;
    } BufferStatus;

    typedef struct packed {
        logic         valid;
        command_t     command;
        logic [0:63]  address;
        logic [0:11]  size;
        trans_order_t abt;
        command_tag_t cmd;
    } CommandBufferLine;

    typedef struct packed {
        logic         valid;
        response_t    response;
        command_tag_t cmd;
    } ResponseBufferLine;

    typedef struct packed {
        logic         valid;
        command_tag_t cmd;
        logic [0:511] data;
    } ReadWriteDataLine;
endpackage

module wed_done_control
    import wed_done_pkg::*;
#(
    parameter logic [0:63] DONE_OFFSET = 64'h0000_0000_0000_0080,
    parameter int          MAX_RETRIES = 4
) (
    input  logic              clock,
    input  logic              rstn,
    input  logic              enabled_in,
    input  logic [0:63]       wed_address,
    input  logic              done_in,
    input  logic [0:63]       status_in,
    input  BufferStatus       command_buffer_status,
    input  ResponseBufferLine wed_response_in,
    output CommandBufferLine  command_out,
    output ReadWriteDataLine  write_data_0_out,
    output ReadWriteDataLine  write_data_1_out,
    output logic              done_out,
    output logic              error_out
);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    localparam command_tag_t TAG_RESET = '{cu_id: INVALID_ID, cmd_type: CMD_INVALID,
        array_struct: STRUCT_INVALID, real_size: '0, tag: '0, cacheline_offset: '0, address_offset: '0};
    localparam command_tag_t TAG_WED = '{cu_id: WED_ID, cmd_type: CMD_WED,
        array_struct: STRUCT_INVALID, real_size: 8'd1, tag: '0, cacheline_offset: '0, address_offset: '0};
    localparam CommandBufferLine CMD_RESET = '{valid: 1'b0, command: INVALID, address: '0,
        size: '0, abt: STRICT, cmd: TAG_RESET};
    localparam ReadWriteDataLine DATA_RESET = '{valid: 1'b0, cmd: TAG_RESET, data: '0};

    typedef enum logic [2:0] {DONE_RESET, DONE_IDLE, DONE_REQ, DONE_WAIT, DONE_ACK, DONE_ERROR} state_t;

    state_t           state, next_state;
    logic             enabled, pending, retry_pend, accept, issue;
    logic             resp_hit, resp_done, resp_retry, alfull;
    logic [RW-1:0]    retries;
    logic [0:63]      status, cycles;
    logic [0:1023]    line;
    CommandBufferLine command_next;
    ReadWriteDataLine data_0_next, data_1_next;
    logic             unused_ok;

    assign alfull     = command_buffer_status.alfull;
    assign resp_hit   = wed_response_in.valid && wed_response_in.cmd.cu_id == WED_ID;
    assign resp_done  = resp_hit && wed_response_in.response == DONE;
    assign resp_retry = resp_hit && !resp_done && retries < RW'(MAX_RETRIES);
    assign accept     = state == DONE_IDLE && enabled && done_in && !pending && !done_out && !error_out;
    assign issue      = next_state == DONE_REQ;
    assign line       = {64'h1, status, cycles, 832'b0};
    assign unused_ok  = &{1'b0, command_buffer_status.full, wed_response_in.cmd, 1'b0};

    always_comb begin
        next_state = state;
        case (state)
            DONE_RESET: next_state = DONE_IDLE;
            DONE_IDLE:  next_state = (pending && !alfull && !done_out && !error_out) ? DONE_REQ : DONE_IDLE;
            DONE_REQ:   next_state = DONE_WAIT;
            DONE_WAIT: begin
                if (resp_done)
                    next_state = DONE_ACK;
                else if (resp_hit && !resp_retry)
                    next_state = DONE_ERROR;
                // A retry decided while alfull is high is remembered in retry_pend until the buffer drains.
                else if ((resp_retry || retry_pend) && !alfull)
                    next_state = DONE_REQ;
            end
            DONE_ACK:   next_state = DONE_IDLE;
            DONE_ERROR: next_state = DONE_ERROR;
            default:    next_state = DONE_RESET;
        endcase
    end

    // Outputs are registered against next_state so the command is visible in the DONE_REQ cycle itself.
    always_comb begin
        command_next = CMD_RESET;
        if (issue) begin
            command_next.valid   = 1'b1;
            command_next.command = WRITE_NA;
            command_next.address = wed_address + DONE_OFFSET;
            command_next.size    = 12'h080;
            command_next.cmd     = TAG_WED;
        end
        data_0_next = issue ? '{valid: 1'b1, cmd: TAG_WED, data: line[0:511]} : DATA_RESET;
        data_1_next = issue ? '{valid: 1'b1, cmd: TAG_WED, data: line[512:1023]} : DATA_RESET;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state            <= DONE_RESET;
            enabled          <= 1'b0;
            pending          <= 1'b0;
            retry_pend       <= 1'b0;
            retries          <= '0;
            status           <= '0;
            done_out         <= 1'b0;
            error_out        <= 1'b0;
            command_out      <= CMD_RESET;
            write_data_0_out <= DATA_RESET;
            write_data_1_out <= DATA_RESET;
        end else begin
            state            <= next_state;
            enabled          <= enabled_in;
            command_out      <= command_next;
            write_data_0_out <= data_0_next;
            write_data_1_out <= data_1_next;
            retry_pend       <= state == DONE_WAIT && (resp_retry || retry_pend) && next_state != DONE_REQ;
            if (state == DONE_WAIT && resp_retry)
                retries <= retries + 1'b1;
            if (accept) begin
                pending <= 1'b1;
                status  <= status_in;
            end
            if (next_state == DONE_ACK) begin
                done_out <= 1'b1;
                pending  <= 1'b0;
            end
            if (next_state == DONE_ERROR)
                error_out <= 1'b1;
        end
    end

`ifdef WED_DONE_CYCLE_COUNT_EN
    // Frozen from the accepting edge onward because pending (then done_out) stays high.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)
            cycles <= '0;
        else if (enabled && !pending && !done_out)
            cycles <= cycles + 64'd1;
    end
`else
    assign cycles = '0;
`endif
endmodule
